// File: rtl/count_direction_decoder.sv
// count_direction_decoder
// Watches the 2-bit value of an external up/down counter, decodes each change
// into an up or down step, accumulates a signed position and reports stalls
// (value unchanged for STALL_LIMIT samples) and illegal double jumps.
//
// Ports
//   clock    : single clock, all state updates on its rising edge
//   resetn   : synchronous active-low reset
//   q        : observed counter value {Q1,Q0}
//   clear    : synchronous clear of position, error and stall tracking
//   dir_up   : last decoded direction (1 = incrementing)
//   step     : one-cycle pulse per legal step
//   position : two's-complement net step count, wraps modulo 2^POS_WIDTH
//   stalled  : high while in STALL
//   error    : sticky illegal-transition flag (high while in ERR)
//   state    : FSM encoding INIT=00, TRACK=01, STALL=10, ERR=11
module count_direction_decoder #(
    parameter int unsigned POS_WIDTH   = 8,
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [1:0]           q,
    input  logic                 clear,
    output logic                 dir_up,
    output logic                 step,
    output logic [POS_WIDTH-1:0] position,
    output logic                 stalled,
    output logic                 error,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StTrack = 2'b01,
        StStall = 2'b10,
        StErr   = 2'b11
    } state_e;

    localparam logic [7:0] Limit = 8'(STALL_LIMIT);

    state_e               state_q, state_d;
    logic [1:0]           q_prev_q, q_prev_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 step_q, step_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [1:0]           delta;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StInit;
            q_prev_q <= 2'b00;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            q_prev_q <= q_prev_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
        end
    end

    // Modulo-4 difference between the new sample and the previous one.
    assign delta = q - q_prev_q;

    always_comb begin
        state_d  = state_q;
        q_prev_d = q;  // previous sample tracks q in every state
        pos_d    = pos_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        cnt_d    = cnt_q;

        if (clear) begin
            // Clear overrides any step or illegal jump decoded this edge.
            state_d = StInit;
            pos_d   = '0;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                StInit: begin
                    state_d = StTrack;
                    cnt_d   = 8'd0;
                end
                StTrack, StStall: begin
                    unique case (delta)
                        2'd1: begin
                            step_d  = 1'b1;
                            dir_d   = 1'b1;
                            pos_d   = pos_q + POS_WIDTH'(1);
                            cnt_d   = 8'd0;
                            state_d = StTrack;
                        end
                        2'd3: begin
                            step_d  = 1'b1;
                            dir_d   = 1'b0;
                            pos_d   = pos_q - POS_WIDTH'(1);
                            cnt_d   = 8'd0;
                            state_d = StTrack;
                        end
                        2'd0: begin
                            // In STALL an unchanged sample holds everything.
                            if (state_q == StTrack) begin
                                cnt_d = (cnt_q >= Limit) ? Limit : cnt_q + 8'd1;
                                if (cnt_d == Limit) begin
                                    state_d = StStall;
                                end
                            end
                        end
                        default: begin
                            state_d = StErr;
                        end
                    endcase
                end
                default: begin
                    // ERR is absorbing; only clear or reset leave it.
                    state_d = StErr;
                end
            endcase
        end
    end

    assign dir_up   = dir_q;
    assign step     = step_q;
    assign position = pos_q;
    assign stalled  = (state_q == StStall);
    assign error    = (state_q == StErr);
    assign state    = state_q;

endmodule

// File: tb/tb_count_direction_decoder.sv
module tb_count_direction_decoder;

    logic       clock;
    logic       resetn;
    logic [1:0] q;
    logic       clear;
    logic       dir_up;
    logic       step;
    logic [7:0] position;
    logic       stalled;
    logic       error;
    logic [1:0] state;

    int compared   = 0;
    int mismatched = 0;
    int pulses;

    count_direction_decoder #(
        .POS_WIDTH  (8),
        .STALL_LIMIT(15)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .q       (q),
        .clear   (clear),
        .dir_up  (dir_up),
        .step    (step),
        .position(position),
        .stalled (stalled),
        .error   (error),
        .state   (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] qv;

        resetn = 1'b0;
        clear  = 1'b0;
        q      = 2'b00;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_pos", 32'(position), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_dir", 32'(dir_up), 32'h0);
        chk("rst_err", 32'(error), 32'h0);
        chk("rst_stall", 32'(stalled), 32'h0);

        // Up sequence: INIT sample, then four up steps.
        resetn = 1'b1;
        q = 2'b00;
        tick();
        chk("init_nostep", 32'(step), 32'h0);
        chk("init_to_track", 32'(state), 32'h1);
        pulses = 0;
        qv = 2'b00;
        for (int i = 0; i < 4; i++) begin
            qv = qv + 2'd1;
            q = qv;
            tick();
            if (step) pulses++;
        end
        chk("up_pulses", 32'(pulses), 32'd4);
        chk("up_pos", 32'(position), 32'd4);
        chk("up_dir", 32'(dir_up), 32'h1);
        chk("up_err", 32'(error), 32'h0);

        // Hold, then two down steps.
        pulses = 0;
        q = 2'b00; tick(); if (step) pulses++;
        q = 2'b11; tick(); if (step) pulses++;
        q = 2'b10; tick(); if (step) pulses++;
        chk("dn_pulses", 32'(pulses), 32'd2);
        chk("dn_pos", 32'(position), 32'd2);
        chk("dn_dir", 32'(dir_up), 32'h0);

        // Stall boundary: 14 holds still tracking, 15th enters STALL.
        for (int i = 0; i < 14; i++) tick();
        chk("stall_14", 32'(stalled), 32'h0);
        tick();
        chk("stall_15", 32'(stalled), 32'h1);
        chk("stall_state", 32'(state), 32'h2);
        tick();
        chk("stall_hold", 32'(state), 32'h2);
        q = 2'b11;
        tick();
        chk("unstall", 32'(stalled), 32'h0);
        chk("unstall_pos", 32'(position), 32'd3);
        chk("unstall_step", 32'(step), 32'h1);

        // Illegal jump into ERR.
        q = 2'b00; tick();
        q = 2'b01; tick();
        chk("pre_err_pos", 32'(position), 32'd5);
        q = 2'b11; tick();
        chk("err_flag", 32'(error), 32'h1);
        chk("err_state", 32'(state), 32'h3);
        chk("err_pos", 32'(position), 32'd5);
        chk("err_step", 32'(step), 32'h0);
        q = 2'b00; tick();
        chk("err_ignore_pos", 32'(position), 32'd5);
        chk("err_ignore_step", 32'(step), 32'h0);
        chk("err_absorb", 32'(state), 32'h3);
        clear = 1'b1; tick();
        chk("clr_err", 32'(error), 32'h0);
        chk("clr_pos", 32'(position), 32'h0);
        chk("clr_state", 32'(state), 32'h0);
        chk("clr_dir_held", 32'(dir_up), 32'h1);
        clear = 1'b0; tick();
        chk("clr_to_track", 32'(state), 32'h1);

        // Clear coinciding with a legal up step.
        q = 2'b01; clear = 1'b1; tick();
        chk("clrstep_pos", 32'(position), 32'h0);
        chk("clrstep_step", 32'(step), 32'h0);
        chk("clrstep_state", 32'(state), 32'h0);
        clear = 1'b0; tick();

        // Wrap: 130 up steps from 0.
        qv = 2'b01;
        for (int i = 0; i < 130; i++) begin
            qv = qv + 2'd1;
            q = qv;
            tick();
            if (i == 126) chk("wrap_127", 32'(position), 32'h7F);
            if (i == 127) chk("wrap_128", 32'(position), 32'h80);
        end
        chk("wrap_130", 32'(position), 32'h82);

        // Reach position 7 in STALL, then reset for one edge.
        clear = 1'b1; tick();
        clear = 1'b0; tick();
        for (int i = 0; i < 7; i++) begin
            qv = qv + 2'd1;
            q = qv;
            tick();
        end
        for (int i = 0; i < 15; i++) tick();
        chk("pos7", 32'(position), 32'd7);
        chk("pos7_stall", 32'(stalled), 32'h1);
        resetn = 1'b0;
        qv = qv + 2'd1;
        q = qv;
        tick();
        chk("mid_rst_state", 32'(state), 32'h0);
        chk("mid_rst_pos", 32'(position), 32'h0);
        chk("mid_rst_stall", 32'(stalled), 32'h0);
        chk("mid_rst_dir", 32'(dir_up), 32'h0);
        chk("mid_rst_step", 32'(step), 32'h0);
        resetn = 1'b1;
        q = 2'b01;
        tick();
        chk("post_rst_nostep", 32'(step), 32'h0);
        chk("post_rst_pos", 32'(position), 32'h0);
        q = 2'b00;
        tick();
        chk("neg_wrap", 32'(position), 32'hFF);
        chk("neg_step", 32'(step), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
